// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM states, default width.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int OPCODE_WIDTH       = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'b0000;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'b0110;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two requester channels plus one result channel for the shared ALU.
// Latency: none (wires only).
// Backpressure: valid/ready on each request channel and on the result channel.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int TAG_WIDTH  = 4
);

  logic                    req0_valid;
  logic                    req0_ready;
  logic [WORD_WIDTH-1:0]   req0_a;
  logic [WORD_WIDTH-1:0]   req0_b;
  logic [OPCODE_WIDTH-1:0] req0_opcode;
  logic [TAG_WIDTH-1:0]    req0_tag;

  logic                    req1_valid;
  logic                    req1_ready;
  logic [WORD_WIDTH-1:0]   req1_a;
  logic [WORD_WIDTH-1:0]   req1_b;
  logic [OPCODE_WIDTH-1:0] req1_opcode;
  logic [TAG_WIDTH-1:0]    req1_tag;

  logic                    res_valid;
  logic                    res_ready;
  logic [WORD_WIDTH-1:0]   res_data;
  logic                    res_carry;
  logic                    res_zero;
  logic                    res_illegal;
  logic                    res_src;
  logic [TAG_WIDTH-1:0]    res_tag;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opcode, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_opcode, req1_tag,
    output req1_ready,
    output res_valid, res_data, res_carry, res_zero, res_illegal, res_src, res_tag,
    input  res_ready
  );

  // Requester / consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_opcode, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_opcode, req1_tag,
    input  req1_ready,
    input  res_valid, res_data, res_carry, res_zero, res_illegal, res_src, res_tag,
    output res_ready
  );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR/NOR with carry, zero and illegal flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [WIDTH-1:0]        result,
  output logic                    carry,
  output logic                    zero,
  output logic                    illegal
);

  logic [WIDTH:0] sum;

  // Widened add so the carry is the unsigned overflow bit
  assign sum = {1'b0, a} + {1'b0, b};

  // Opcode decode; every flag defaulted so carry never goes stale across opcodes
  always @* begin
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      default: illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, tagged result register.
// Latency: request accepted in cycle N, result valid in cycle N+2; one result every 2 cycles.
// Backpressure: result held while res_ready=0; no request is granted until the result is taken.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int TAG_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;

  logic                    can_grant;
  logic                    grant0;
  logic                    grant1;
  logic                    grant_any;

  logic [WORD_WIDTH-1:0]   op_a;
  logic [WORD_WIDTH-1:0]   op_b;
  logic [OPCODE_WIDTH-1:0] op_code;
  logic [TAG_WIDTH-1:0]    op_tag;
  logic                    op_src;

  logic [WORD_WIDTH-1:0]   alu_result;
  logic                    alu_carry;
  logic                    alu_zero;
  logic                    alu_illegal;

  // Grant window opens in IDLE, or in DONE on the cycle the result is consumed
  always_comb begin
    can_grant = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (rst_n) begin
      can_grant = (state == ST_IDLE) || ((state == ST_DONE) && bus.res_ready);
    end
    if (can_grant) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign grant_any      = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Next-state: IDLE -> EXEC on grant, EXEC -> DONE, DONE -> EXEC/IDLE once consumed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (bus.res_ready) state_nxt = grant_any ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and round-robin pointer; pointer resets to 1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_any) last_grant <= grant1;
    end
  end

  // Operand capture on the grant cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      op_tag  <= '0;
      op_src  <= 1'b0;
    end else if (grant_any) begin
      op_a    <= grant1 ? bus.req1_a      : bus.req0_a;
      op_b    <= grant1 ? bus.req1_b      : bus.req0_b;
      op_code <= grant1 ? bus.req1_opcode : bus.req0_opcode;
      op_tag  <= grant1 ? bus.req1_tag    : bus.req0_tag;
      op_src  <= grant1;
    end
  end

  alu_core #(
    .WIDTH (WORD_WIDTH)
  ) u_alu_core (
    .a       (op_a),
    .b       (op_b),
    .opcode  (op_code),
    .result  (alu_result),
    .carry   (alu_carry),
    .zero    (alu_zero),
    .illegal (alu_illegal)
  );

  // Result register: loads at the end of EXEC, valid drops once consumed; payload held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_carry   <= 1'b0;
      bus.res_zero    <= 1'b0;
      bus.res_illegal <= 1'b0;
      bus.res_src     <= 1'b0;
      bus.res_tag     <= '0;
    end else if (state == ST_EXEC) begin
      bus.res_valid   <= 1'b1;
      bus.res_data    <= alu_result;
      bus.res_carry   <= alu_carry;
      bus.res_zero    <= alu_zero;
      bus.res_illegal <= alu_illegal;
      bus.res_src     <= op_src;
      bus.res_tag     <= op_tag;
    end else if ((state == ST_DONE) && bus.res_ready) begin
      bus.res_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, ADD carry, illegal/NOR, contention, backpressure, mid-op reset.
// Latency: stimulus applied 1 time unit after the rising edge; outputs sampled in the same window.
// Backpressure: exercised explicitly through res_ready.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit port, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [3:0] tag);
    if (!port) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_opcode = op; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_opcode = op; bus.req1_tag = tag;
    end
  endtask

  // Presents a request, waits (bounded) for its ready, returns one step after acceptance
  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] tag, output bit ok);
    ok = 1'b0;
    drive_req(port, a, b, op, tag);
    #1;
    for (int n = 0; n < 10; n++) begin
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) step();
    if (!port) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(1'b0, 32'd1, 32'd1, OP_ADD, 4'd1);
    drive_req(1'b1, 32'd2, 32'd2, OP_ADD, 4'd2);
    step(); step();
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b exp 0", bus.req1_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.res_data); end
    checks++; if (bus.res_carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %b exp 0", bus.res_carry); end
    checks++; if (bus.res_zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", bus.res_zero); end
    checks++; if (bus.res_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", bus.res_illegal); end
    checks++; if (bus.res_src !== 1'b0) begin errors++; $display("FAIL rst_src got %b exp 0", bus.res_src); end
    checks++; if (bus.res_tag !== 4'h0) begin errors++; $display("FAIL rst_tag got %h exp 0", bus.res_tag); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL first_grant_ready0 got %b exp 1", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL first_grant_ready1 got %b exp 0", bus.req1_ready); end
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'd2) begin errors++; $display("FAIL first_data got %h exp 2", bus.res_data); end
    checks++; if (bus.res_src !== 1'b0) begin errors++; $display("FAIL first_src got %b exp 0", bus.res_src); end
    checks++; if (bus.res_tag !== 4'd1) begin errors++; $display("FAIL first_tag got %h exp 1", bus.res_tag); end
    step();
  endtask

  task automatic test_single_add();
    drive_req(1'b0, 32'hFFFF_FFFF, 32'd1, OP_ADD, 4'd3);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready0 got %b exp 1", bus.req0_ready); end
    step();
    bus.req0_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid got %b exp 0", bus.res_valid); end
    step();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL add_data got %h exp 0", bus.res_data); end
    checks++; if (bus.res_carry !== 1'b1) begin errors++; $display("FAIL add_carry got %b exp 1", bus.res_carry); end
    checks++; if (bus.res_zero !== 1'b1) begin errors++; $display("FAIL add_zero got %b exp 1", bus.res_zero); end
    checks++; if (bus.res_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got %b exp 0", bus.res_illegal); end
    checks++; if (bus.res_src !== 1'b0) begin errors++; $display("FAIL add_src got %b exp 0", bus.res_src); end
    checks++; if (bus.res_tag !== 4'd3) begin errors++; $display("FAIL add_tag got %h exp 3", bus.res_tag); end
    step();
  endtask

  task automatic test_illegal_logic();
    bit ok;
    issue(1'b1, 32'd5, 32'd3, 4'b1111, 4'd9, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ill_grant got %b exp 1", ok); end
    wait_result(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ill_result got %b exp 1", ok); end
    checks++; if (bus.res_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", bus.res_illegal); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL ill_data got %h exp 0", bus.res_data); end
    checks++; if (bus.res_zero !== 1'b1) begin errors++; $display("FAIL ill_zero got %b exp 1", bus.res_zero); end
    checks++; if (bus.res_carry !== 1'b0) begin errors++; $display("FAIL ill_carry got %b exp 0", bus.res_carry); end
    checks++; if (bus.res_src !== 1'b1) begin errors++; $display("FAIL ill_src got %b exp 1", bus.res_src); end
    checks++; if (bus.res_tag !== 4'd9) begin errors++; $display("FAIL ill_tag got %h exp 9", bus.res_tag); end
    step();
    issue(1'b1, 32'd0, 32'd0, OP_NOR, 4'd10, ok);
    wait_result(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nor_result got %b exp 1", ok); end
    checks++; if (bus.res_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nor_data got %h exp ffffffff", bus.res_data); end
    checks++; if (bus.res_zero !== 1'b0) begin errors++; $display("FAIL nor_zero got %b exp 0", bus.res_zero); end
    checks++; if (bus.res_illegal !== 1'b0) begin errors++; $display("FAIL nor_illegal got %b exp 0", bus.res_illegal); end
    checks++; if (bus.res_tag !== 4'd10) begin errors++; $display("FAIL nor_tag got %h exp a", bus.res_tag); end
    step();
  endtask

  task automatic test_contention();
    drive_req(1'b0, 32'd10, 32'd3, OP_SUB, 4'd5);
    drive_req(1'b1, 32'd5, 32'd8, OP_OR, 4'd6);
    #1;
    for (int i = 0; i < 4; i++) begin
      bit g;
      logic [31:0] exp_data;
      logic [3:0]  exp_tag;
      g        = (i % 2) == 1;
      exp_data = g ? 32'd13 : 32'd7;
      exp_tag  = g ? 4'd6 : 4'd5;
      checks++; if (bus.req0_ready !== !g) begin errors++; $display("FAIL cont_ready0[%0d] got %b exp %b", i, bus.req0_ready, !g); end
      checks++; if (bus.req1_ready !== g) begin errors++; $display("FAIL cont_ready1[%0d] got %b exp %b", i, bus.req1_ready, g); end
      step();
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL cont_exec_valid[%0d] got %b exp 0", i, bus.res_valid); end
      step();
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL cont_valid[%0d] got %b exp 1", i, bus.res_valid); end
      checks++; if (bus.res_data !== exp_data) begin errors++; $display("FAIL cont_data[%0d] got %h exp %h", i, bus.res_data, exp_data); end
      checks++; if (bus.res_src !== g) begin errors++; $display("FAIL cont_src[%0d] got %b exp %b", i, bus.res_src, g); end
      checks++; if (bus.res_carry !== 1'b0) begin errors++; $display("FAIL cont_carry[%0d] got %b exp 0", i, bus.res_carry); end
      checks++; if (bus.res_tag !== exp_tag) begin errors++; $display("FAIL cont_tag[%0d] got %h exp %h", i, bus.res_tag, exp_tag); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    drive_req(1'b0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 4'd7);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", bus.req0_ready); end
    step();
    bus.req0_valid = 1'b0;
    drive_req(1'b1, 32'd5, 32'd6, OP_ADD, 4'd8);
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready1 got %b exp 0", bus.req1_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", k, bus.res_valid); end
      checks++; if (bus.res_data !== 32'h0000_F000) begin errors++; $display("FAIL bp_data[%0d] got %h exp 0000f000", k, bus.res_data); end
      checks++; if (bus.res_tag !== 4'd7) begin errors++; $display("FAIL bp_tag[%0d] got %h exp 7", k, bus.res_tag); end
      checks++; if (bus.res_src !== 1'b0) begin errors++; $display("FAIL bp_src[%0d] got %b exp 0", k, bus.res_src); end
      checks++; if ((bus.req0_ready | bus.req1_ready) !== 1'b0) begin errors++; $display("FAIL bp_noready[%0d] got %b%b exp 00", k, bus.req0_ready, bus.req1_ready); end
      step();
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready1 got %b exp 1", bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b exp 0", bus.res_valid); end
    step();
    checks++; if (bus.res_data !== 32'd11) begin errors++; $display("FAIL bp_next_data got %h exp b", bus.res_data); end
    checks++; if (bus.res_src !== 1'b1) begin errors++; $display("FAIL bp_next_src got %b exp 1", bus.res_src); end
    checks++; if (bus.res_tag !== 4'd8) begin errors++; $display("FAIL bp_next_tag got %h exp 8", bus.res_tag); end
    step();
  endtask

  task automatic test_mid_reset();
    bit ok;
    issue(1'b0, 32'd1, 32'd2, OP_ADD, 4'd4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mr_grant got %b exp 1", ok); end
    rst_n = 1'b0;
    drive_req(1'b1, 32'd9, 32'd9, OP_ADD, 4'd1);
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL mr_ready1 got %b exp 0", bus.req1_ready); end
    step();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h0) begin errors++; $display("FAIL mr_data got %h exp 0", bus.res_data); end
    rst_n = 1'b1;
    bus.req1_valid = 1'b0;
    step();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_after1 got %b exp 0", bus.res_valid); end
    step();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mr_valid_after2 got %b exp 0", bus.res_valid); end
    issue(1'b0, 32'd7, 32'd8, OP_ADD, 4'd2, ok);
    wait_result(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mr_next_result got %b exp 1", ok); end
    checks++; if (bus.res_data !== 32'd15) begin errors++; $display("FAIL mr_next_data got %h exp f", bus.res_data); end
    checks++; if (bus.res_tag !== 4'd2) begin errors++; $display("FAIL mr_next_tag got %h exp 2", bus.res_tag); end
    checks++; if (bus.res_carry !== 1'b0) begin errors++; $display("FAIL mr_next_carry got %b exp 0", bus.res_carry); end
    step();
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req0_valid  = 1'b0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_opcode = '0;
    bus.req0_tag    = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.req1_opcode = '0;
    bus.req1_tag    = '0;
    bus.res_ready   = 1'b1;
    test_reset();
    test_single_add();
    test_illegal_logic();
    test_contention();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance between two requesters, e.g. the EX stage (port 0) and a multi-cycle helper unit (port 1).
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Operands are captured in registers, the ALU is evaluated on those registers, and the result is held in an output register with a tag until the consumer accepts it.

Parameters:
- WORD_WIDTH, 32: operand and result width.
- TAG_WIDTH, 4: width of the requester-supplied transaction tag returned with the result.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WORD_WIDTH each  signed operands.
- req0_opcode  in  4  ALU opcode.
- req0_tag  in  TAG_WIDTH  returned with the result.
- req1_valid, req1_ready, req1_a, req1_b, req1_opcode, req1_tag: same as the port-0 signals, for requester 1.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WORD_WIDTH  result.
- res_carry  out  1  carry out (ADD only).
- res_zero  out  1  res_data == 0.
- res_illegal  out  1  opcode was not in the supported set.
- res_src  out  1  requester index (0 or 1).
- res_tag  out  TAG_WIDTH  tag of the request.

Behaviour:
- Opcodes (shared package):
  - ADD = 4'b0010: {carry, result} = a + b, computed at WORD_WIDTH+1 bits, unsigned carry.
  - SUB = 4'b0110: a - b.
  - AND = 4'b0000.
  - OR = 4'b0001.
  - NOR = 4'b1100.
  - Any other opcode: result 0, carry 0, illegal = 1, zero = 1.
- Carry is 0 for every opcode except ADD. It is never left stale.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if any reqN_valid, grant one requester, assert its ready for that cycle, capture a, b, opcode, tag and src into operand registers, then go to EXEC.
  - EXEC: the ALU evaluates the operand registers. All result fields load into the output registers. res_valid = 1 from the next cycle. Go to DONE.
  - DONE: hold all res_* stable while res_valid && !res_ready. When res_ready = 1:
    - If any request is valid in the same cycle, grant and capture it, then go to EXEC (back-to-back: one result every 2 cycles).
    - Otherwise go to IDLE.
    - res_valid drops in the following cycle unless a new result is loading.
- Latency: request accepted at edge N, res_valid = 1 after edge N+2 (visible in cycle N+2).
- Ready signals:
  - reqN_ready is combinational from state, valids and res_ready.
  - At most one reqN_ready is high per cycle.
  - ready is never asserted without the matching valid.
- Round-robin: a 1-bit last_grant register, reset to 1 so requester 0 wins first.
  - When both requesters are valid, grant !last_grant.
  - When one is valid, grant it.
  - last_grant updates only on a grant.
- Requesters must hold valid and payload stable until ready. The block does not depend on this beyond the capture cycle.
- Reset (rst_n = 0 at an edge), from any state:
  - state goes to IDLE and last_grant to 1.
  - res_valid, res_data, res_carry, res_zero, res_illegal, res_src and res_tag all go to 0.
  - Operand registers go to 0.
  - Any in-flight operation is discarded with no output.
  - req0_ready and req1_ready are 0 while rst_n = 0.
- res_* outputs change only on the edge that loads a new result or on reset.

Decomposition:
- Package alu_pkg holds: the opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR), the FSM state encodings (ST_IDLE, ST_EXEC, ST_DONE) and the default WORD_WIDTH.
- One sub-module, alu_core: a purely combinational (always @*) ALU with inputs a, b, opcode and outputs result, carry, zero, illegal. It is instantiated once on the operand registers.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with both valids high. Required: both readies 0, all res_* = 0. After release, req0 is granted first.
- Single ADD: req0 a = 32'hFFFFFFFF, b = 1, opcode 0010, tag 3. Required: 2 cycles later res_data = 0, res_carry = 1, res_zero = 1, res_src = 0, res_tag = 3.
- Contention: both requesters valid continuously; req0 SUB 10 - 3, req1 OR 5 | 8. Required:
  - grants alternate 0, 1, 0, 1;
  - results 7 (src 0) and 13 (src 1) alternate;
  - res_carry = 0 on each.
- Backpressure: res_ready = 0 for 5 cycles after res_valid. Required: res_* stay stable, no reqN_ready asserted. When res_ready = 1, a pending request is granted that same cycle.
- Illegal and logic ops: opcode 4'b1111 gives res_illegal = 1, res_data = 0, res_zero = 1. NOR 0, 0 gives 32'hFFFFFFFF with zero = 0.
- Mid-operation reset: assert rst_n = 0 in EXEC. Required: no result emerges, res_valid = 0, and the next request completes normally.
